// File: rtl/opseq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : opseq_pkg
//  Description : Shared state, operand-select and width definitions for the
//                operand sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package opseq_pkg;

    localparam int OPND_W   = 4;
    localparam int RES_W    = 5;
    localparam int BUNDLE_W = 4 * OPND_W;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE = 3'd0;
    localparam state_t ST_SEND = 3'd1;
    localparam state_t ST_GAP  = 3'd2;
    localparam state_t ST_WAIT = 3'd3;
    localparam state_t ST_RESP = 3'd4;

    localparam logic [1:0] OP_A = 2'd0;
    localparam logic [1:0] OP_B = 2'd1;
    localparam logic [1:0] OP_C = 2'd2;
    localparam logic [1:0] OP_D = 2'd3;

    localparam logic [RES_W-1:0] ERR_RESULT = 5'h1F;

endpackage : opseq_pkg
`default_nettype wire

// File: rtl/opseq_nibble_mux.sv
`default_nettype none
// ============================================================================
//  Module      : opseq_nibble_mux
//  Description : Selects one 4-bit operand (A..D) out of a 16-bit bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
module opseq_nibble_mux
    import opseq_pkg::*;
(
    input  logic [BUNDLE_W-1:0] i_bundle,
    input  logic [1:0]          i_op,
    output logic [OPND_W-1:0]   o_nibble
);

    // A sits in the most significant nibble, D in the least
    always_comb begin
        o_nibble = '0;
        case (i_op)
            OP_A:    o_nibble = i_bundle[15:12];
            OP_B:    o_nibble = i_bundle[11:8];
            OP_C:    o_nibble = i_bundle[7:4];
            OP_D:    o_nibble = i_bundle[3:0];
            default: o_nibble = '0;
        endcase
    end

endmodule : opseq_nibble_mux
`default_nettype wire

// File: rtl/operand_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : operand_sequencer
//  Description : Accepts an A/B/C/D operand bundle, strobes each operand into
//                the compute unit, waits for its result and hands it on.
//                Optional macro OPSEQ_TIMEOUT_EN adds a WAIT-state timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module operand_sequencer
    import opseq_pkg::*;
#(
    parameter int CAP_GAP = 0,
    parameter int TIMEOUT = 32
) (
    input  logic                clock,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BUNDLE_W-1:0] in_data,
    output logic [OPND_W-1:0]   cap_data,
    output logic [1:0]          cap_op,
    output logic                cap_strobe,
    input  logic [RES_W-1:0]    res_in,
    input  logic                res_valid,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [RES_W-1:0]    out_result,
    output logic                err
);

    localparam logic [3:0] GAP_LAST = 4'((CAP_GAP > 0) ? CAP_GAP - 1 : 0);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [1:0]          r_op;
    logic [1:0]          w_op_nxt;
    logic [3:0]          r_gap;
    logic [BUNDLE_W-1:0] r_bundle;
    logic [BUNDLE_W-1:0] w_bundle;
    logic [OPND_W-1:0]   w_nibble;
    logic [RES_W-1:0]    r_result;
    logic                r_cap_strobe;
    logic [1:0]          r_cap_op;
    logic [OPND_W-1:0]   r_cap_data;
    logic                w_accept;
    logic                w_timeout;
    logic                w_send_nxt;

    assign in_ready   = (r_state == ST_IDLE) && !rst;
    assign out_valid  = (r_state == ST_RESP);
    assign out_result = r_result;
    assign cap_strobe = r_cap_strobe;
    assign cap_op     = r_cap_op;
    assign cap_data   = r_cap_data;
    assign w_accept   = in_valid && in_ready;
    assign w_send_nxt = (w_state_nxt == ST_SEND);

`ifdef OPSEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(TIMEOUT);

    logic [TO_W-1:0] r_to;
    logic            r_err;

    assign w_timeout = (r_state == ST_WAIT) && !res_valid && (r_to == TO_LAST);
    assign err       = r_err;

    always_ff @(posedge clock) begin
        if (rst) begin
            r_to  <= '0;
            r_err <= 1'b0;
        end else begin
            if (r_state != ST_WAIT) begin
                r_to <= '0;
            end else if (r_to != TO_MAX) begin
                r_to <= r_to + TO_W'(1);
            end
            if (w_accept) begin
                r_err <= 1'b0;
            end else if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SEND;
                    w_op_nxt    = OP_A;
                end
            end
            ST_SEND: begin
                if (r_op == OP_D) begin
                    w_state_nxt = ST_WAIT;
                end else begin
                    w_op_nxt    = r_op + 2'd1;
                    w_state_nxt = (CAP_GAP > 0) ? ST_GAP : ST_SEND;
                end
            end
            ST_GAP: begin
                if (r_gap == GAP_LAST) begin
                    w_state_nxt = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (res_valid || w_timeout) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // On the accept edge the bundle is not registered yet, so bypass it
    assign w_bundle = w_accept ? in_data : r_bundle;

    opseq_nibble_mux u_nibble_mux (
        .i_bundle (w_bundle),
        .i_op     (w_op_nxt),
        .o_nibble (w_nibble)
    );

    always_ff @(posedge clock) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_op         <= '0;
            r_gap        <= '0;
            r_bundle     <= '0;
            r_result     <= '0;
            r_cap_strobe <= 1'b0;
            r_cap_op     <= '0;
            r_cap_data   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            if (w_accept) begin
                r_bundle <= in_data;
            end
            if ((r_state == ST_GAP) && (r_gap != GAP_LAST)) begin
                r_gap <= r_gap + 4'd1;
            end else begin
                r_gap <= '0;
            end
            if (r_state == ST_WAIT) begin
                if (res_valid) begin
                    r_result <= res_in;
                end else if (w_timeout) begin
                    r_result <= ERR_RESULT;
                end
            end
            // Strobe outputs are registered from the next state so they line up with SEND
            r_cap_strobe <= w_send_nxt;
            r_cap_op     <= w_send_nxt ? w_op_nxt : 2'd0;
            r_cap_data   <= w_send_nxt ? w_nibble : '0;
        end
    end

endmodule : operand_sequencer
`default_nettype wire
